// File: rtl/flow_pkg.sv
// Shared definitions for the flow entry writer: FSM state encodings,
// error codes and a small helper for the per-state wait counter.
package flow_pkg;

  typedef logic [2:0] flow_state_t;

  localparam flow_state_t ST_IDLE  = 3'd0;
  localparam flow_state_t ST_ISSUE = 3'd1;
  localparam flow_state_t ST_ACK   = 3'd2;
  localparam flow_state_t ST_NEXT  = 3'd3;
  localparam flow_state_t ST_DONE  = 3'd4;
  localparam flow_state_t ST_ERR   = 3'd5;
  localparam flow_state_t ST_VRD   = 3'd6;
  localparam flow_state_t ST_VACK  = 3'd7;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_VERIFY  = 2'd2;

  // States that wait on a mem_ready_i transition and are therefore bounded
  // by the timeout counter.
  function automatic logic is_wait_state(input flow_state_t s);
    return (s == ST_ISSUE) || (s == ST_ACK) || (s == ST_VRD) || (s == ST_VACK);
  endfunction

endpackage

// File: rtl/flow_req_fifo.sv
// Request queue for the flow entry writer: show-ahead synchronous FIFO with
// occupancy count. Push while full and pop while empty are ignored.
module flow_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/flow_entry_writer.sv
// Flow entry writer: queues whole match-table entries and writes them word by
// word to the switch ctrl_mem port using the ce/we/ready handshake.
//
// Handshakes:
//   request side: an entry is pushed on a rising clk edge where req_valid_i
//   and req_ready_o are both high (req_ready_o = queue not full).
//   memory side: the writer raises ce (and we for writes) with addr/data and
//   holds them; the memory accepts by pulling mem_ready_i low and completes
//   by returning it high. Every such wait is bounded by TIMEOUT_CYC cycles.
//
// Build option: define FLOW_WR_VERIFY_EN to read back every word after it is
// written and abort the entry with error code 2 on a mismatch.
module flow_entry_writer #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int WORDS_PER_ENTRY = 4,
  parameter int ENTRY_STRIDE    = 16,
  parameter int QUEUE_DEPTH     = 4,
  parameter int TIMEOUT_CYC     = 255
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                req_valid_i,
  output logic                                req_ready_o,
  input  logic [ADDR_W-1:0]                   req_base_i,
  input  logic [15:0]                         req_index_i,
  input  logic [WORDS_PER_ENTRY*DATA_W-1:0]   req_entry_i,
  output logic                                mem_ce_o,
  output logic                                mem_we_o,
  output logic [ADDR_W-1:0]                   mem_addr_o,
  output logic [DATA_W-1:0]                   mem_data_o,
  input  logic [DATA_W-1:0]                   mem_data_i,
  input  logic                                mem_ready_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                err_o,
  output logic [1:0]                          err_code_o,
  output logic [$clog2(QUEUE_DEPTH):0]        q_count_o
);

  import flow_pkg::*;

  localparam int BYTES   = DATA_W / 8;
  localparam int ENTRY_W = WORDS_PER_ENTRY * DATA_W;
  localparam int REQ_W   = ADDR_W + ENTRY_W;
  localparam int WIDX_W  = (WORDS_PER_ENTRY > 1) ? $clog2(WORDS_PER_ENTRY) : 1;
  localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [WIDX_W-1:0] W_LAST  = WIDX_W'(WORDS_PER_ENTRY - 1);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ADDR_W-1:0]   push_addr;
  logic [REQ_W-1:0]    fifo_din;
  logic [REQ_W-1:0]    fifo_dout;

  flow_state_t         state;
  flow_state_t         state_nxt;
  logic [WIDX_W-1:0]   w;
  logic                last_q;
  logic [ADDR_W-1:0]   cur_addr;
  logic [ENTRY_W-1:0]  cur_entry;
  logic [TO_W-1:0]     wait_cnt;
  logic                wait_exp;
  logic [1:0]          err_code_q;
  logic [1:0]          err_nxt;
  logic [DATA_W-1:0]   word_data;
  logic                word_end;

  // The entry start address is resolved at push time so the queue only
  // carries one address; arithmetic wraps modulo 2^ADDR_W.
  assign push_addr = req_base_i + ADDR_W'(req_index_i) * ADDR_W'(ENTRY_STRIDE);
  assign push      = req_valid_i && !fifo_full;
  assign fifo_din  = {push_addr, req_entry_i};

  flow_req_fifo #(
    .W     (REQ_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (q_count_o)
  );

  assign wait_exp = (wait_cnt == TO_LAST);
  assign word_end = (state_nxt == ST_NEXT) && (state != ST_NEXT);

  // Select the current word; word 0 sits in the most significant bits.
  always_comb begin
    word_data = '0;
    for (int i = 0; i < WORDS_PER_ENTRY; i++) begin
      if (w == WIDX_W'(i)) word_data = cur_entry[(WORDS_PER_ENTRY-1-i)*DATA_W +: DATA_W];
    end
  end

  // Next-state logic for the write sequencer.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    err_nxt   = err_code_q;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!mem_ready_i) begin
          state_nxt = ST_ACK;
        end else if (wait_exp) begin
          state_nxt = ST_ERR;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      ST_ACK: begin
        if (mem_ready_i) begin
`ifdef FLOW_WR_VERIFY_EN
          state_nxt = ST_VRD;
`else
          state_nxt = ST_NEXT;
`endif
        end else if (wait_exp) begin
          state_nxt = ST_ERR;
          err_nxt   = ERR_TIMEOUT;
        end
      end
`ifdef FLOW_WR_VERIFY_EN
      ST_VRD: begin
        if (!mem_ready_i) begin
          state_nxt = ST_VACK;
        end else if (wait_exp) begin
          state_nxt = ST_ERR;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      ST_VACK: begin
        if (mem_ready_i) begin
          if (mem_data_i != word_data) begin
            state_nxt = ST_ERR;
            err_nxt   = ERR_VERIFY;
          end else begin
            state_nxt = ST_NEXT;
          end
        end else if (wait_exp) begin
          state_nxt = ST_ERR;
          err_nxt   = ERR_TIMEOUT;
        end
      end
`endif
      ST_NEXT: state_nxt = last_q ? ST_DONE : ST_ISSUE;
      ST_DONE: state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer registers: state, word pointer, captured entry, wait counter.
  // The word pointer advances on entry to NEXT so NEXT already presents the
  // following word while ce stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      w          <= '0;
      last_q     <= 1'b0;
      cur_addr   <= '0;
      cur_entry  <= '0;
      wait_cnt   <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state      <= state_nxt;
      err_code_q <= err_nxt;
      if (pop) begin
        cur_addr  <= fifo_dout[REQ_W-1 -: ADDR_W];
        cur_entry <= fifo_dout[ENTRY_W-1:0];
        w         <= '0;
        last_q    <= 1'b0;
      end else if (word_end) begin
        last_q <= (w == W_LAST);
        if (w != W_LAST) w <= w + 1'b1;
      end
      if (state_nxt != state) begin
        wait_cnt <= '0;
      end else if (is_wait_state(state)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

`ifndef FLOW_WR_VERIFY_EN
  logic unused_rd_data;
  assign unused_rd_data = ^mem_data_i;
`endif

  // Outputs decode straight from registered state, so reset drops ce/we
  // without waiting for a clock edge.
  assign mem_ce_o    = is_wait_state(state) || ((state == ST_NEXT) && !last_q);
  assign mem_we_o    = (state == ST_ISSUE) || (state == ST_ACK) ||
                       ((state == ST_NEXT) && !last_q);
  assign mem_addr_o  = cur_addr + ADDR_W'(w) * ADDR_W'(BYTES);
  assign mem_data_o  = word_data;
  assign req_ready_o = !fifo_full;
  assign busy_o      = (state != ST_IDLE) || !fifo_empty;
  assign done_o      = (state == ST_DONE);
  assign err_o       = (state == ST_ERR);
  assign err_code_o  = (state == ST_ERR) ? err_code_q : ERR_NONE;

endmodule

// File: tb/tb_flow_entry_writer.sv
// Directed bench for flow_entry_writer: single entry, full queue, timeout,
// reset mid-write, address wrap and (with FLOW_WR_VERIFY_EN) read-back error.
module tb_flow_entry_writer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [31:0]  req_base_i;
  logic [15:0]  req_index_i;
  logic [127:0] req_entry_i;
  logic         mem_ce_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [31:0]  mem_data_o;
  logic [31:0]  mem_data_i;
  logic         mem_ready_i;
  logic         busy_o;
  logic         done_o;
  logic         err_o;
  logic [1:0]   err_code_o;
  logic [2:0]   q_count_o;

  flow_entry_writer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_base_i  (req_base_i),
    .req_index_i (req_index_i),
    .req_entry_i (req_entry_i),
    .mem_ce_o    (mem_ce_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_ready_i (mem_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .err_code_o  (err_code_o),
    .q_count_o   (q_count_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_bad    = 0;
  logic [63:0] exp_q[$];           // {addr, data} of writes still expected

  // memory model knobs
  int  m_acc = 0;                  // cycles of ce before accepting
  int  m_busy = 2;                 // extra cycles ready stays low
  bit  m_stuck = 0;                // never accept (ready stays high)
  bit  m_corrupt = 0;              // flip bit 0 of read data at m_corrupt_addr
  logic [31:0] m_corrupt_addr = '0;
  int  m_state = 0;
  int  m_cnt = 0;
  logic [31:0] mem_model [logic [31:0]];

  // monitors
  int done_cnt = 0;
  int err_cnt  = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;
  int ce_total = 0;
  int ce_run   = 0;
  int last_run = 0;
  int err_run  = 0;
  int q_peak   = 0;
  logic [1:0] last_err = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory accepts the current request: log it and pull ready low.
  task automatic accept();
    logic [63:0] got;
    logic [63:0] exp;
    if (mem_we_o) begin
      got = {mem_addr_o, mem_data_o};
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : ~got;
      check("wr", got, exp);
      mem_model[mem_addr_o] = mem_data_o;
      wr_cnt++;
    end else begin
      mem_data_i = mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o] : 32'h0;
      if (m_corrupt && (mem_addr_o == m_corrupt_addr)) mem_data_i = mem_data_i ^ 32'h1;
      rd_cnt++;
    end
    mem_ready_i = 1'b0;
    m_cnt       = m_busy;
    m_state     = 2;
  endtask

  // ctrl_mem model and event monitors, evaluated on the falling edge.
  initial begin
    mem_ready_i = 1'b1;
    mem_data_i  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ready_i = 1'b1;
        m_state     = 0;
      end else begin
        if (mem_ce_o) begin
          ce_run++;
          ce_total++;
        end else if (ce_run > 0) begin
          last_run = ce_run;
          ce_run   = 0;
        end
        if (done_o) done_cnt++;
        if (err_o) begin
          err_cnt++;
          last_err = err_code_o;
          err_run  = last_run;
        end
        if (int'(q_count_o) > q_peak) q_peak = int'(q_count_o);
        case (m_state)
          0: if (mem_ce_o && !m_stuck) begin
               if (m_acc == 0) accept();
               else begin
                 m_cnt   = m_acc;
                 m_state = 1;
               end
             end
          1: begin
               m_cnt--;
               if (m_cnt == 0) accept();
             end
          default: begin
               if (m_cnt == 0) begin
                 mem_ready_i = 1'b1;
                 m_state     = 0;
               end else m_cnt--;
             end
        endcase
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Push one entry; the first n_exp words are queued as expected writes.
  task automatic push_entry(input logic [31:0] base, input logic [15:0] idx,
                            input logic [127:0] entry, input int n_exp);
    int n = 0;
    logic [31:0] a;
    for (int wi = 0; wi < n_exp; wi++) begin
      a = base + {idx, 4'h0} + 32'(wi * 4);
      exp_q.push_back({a, entry[127 - 32*wi -: 32]});
    end
    req_valid_i = 1'b1;
    req_base_i  = base;
    req_index_i = idx;
    req_entry_i = entry;
    while (!req_ready_o && n < 500) begin
      tick();
      n++;
    end
    check("push_ready", req_ready_o, 1'b1);
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check("done_count", done_cnt, target);
  endtask

  task automatic wait_err(input int target, input int budget);
    int n = 0;
    while (err_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check("err_count", err_cnt, target);
  endtask

  task automatic wait_wr(input int target, input int budget);
    int n = 0;
    while (wr_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check("wr_count", wr_cnt, target);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d0;
    int e0;
    int w0;
    int c0;
    req_valid_i = 1'b0;
    req_base_i  = '0;
    req_index_i = '0;
    req_entry_i = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    check("rst_ready",  req_ready_o, 1'b1);
    check("rst_ce",     mem_ce_o,    1'b0);
    check("rst_we",     mem_we_o,    1'b0);
    check("rst_addr",   mem_addr_o,  32'h0);
    check("rst_data",   mem_data_o,  32'h0);
    check("rst_busy",   busy_o,      1'b0);
    check("rst_done",   done_o,      1'b0);
    check("rst_err",    err_o,       1'b0);
    check("rst_code",   err_code_o,  2'd0);
    check("rst_qcount", q_count_o,   3'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single entry, hand-computed addresses: 0x00100000 + 136*16 = 0x00100880
    m_acc  = 1;
    m_busy = 2;
    exp_q.push_back({32'h00100880, 32'h0100b7ac});
    exp_q.push_back({32'h00100884, 32'hf62c0000});
    exp_q.push_back({32'h00100888, 32'habcdef01});
    exp_q.push_back({32'h0010088c, 32'h23450001});
    push_entry(32'h00100000, 16'd136, {32'h0100b7ac, 32'hf62c0000, 32'habcdef01, 32'h23450001}, 0);
    check("lat_ce_low", mem_ce_o, 1'b0);
    tick();
    check("lat_ce_high", mem_ce_o, 1'b1);
    check("lat_we",      mem_we_o, 1'b1);
    check("lat_addr",    mem_addr_o, 32'h00100880);
    check("lat_data",    mem_data_o, 32'h0100b7ac);
    wait_done(1, 300);
    tick();
    check("single_err",  err_cnt, 0);
    check("single_left", exp_q.size(), 0);
    check("single_busy", busy_o, 1'b0);

    // Queue full: one entry is taken by the sequencer right away, so after
    // five back-to-back pushes four remain queued and the queue is full.
    m_acc  = 0;
    m_busy = 20;
    q_peak = 0;
    for (int i = 0; i < 5; i++) begin
      push_entry(32'h00002000, 16'(i),
                 {32'hc0de0000 | 32'(i << 4), 32'hc0de0001 | 32'(i << 4),
                  32'hc0de0002 | 32'(i << 4), 32'hc0de0003 | 32'(i << 4)}, 4);
    end
    check("full_ready", req_ready_o, 1'b0);
    check("full_count", q_count_o, 3'd4);
    // A request held while full must not enter the queue.
    req_valid_i = 1'b1;
    req_base_i  = 32'h00009000;
    req_index_i = 16'd9;
    req_entry_i = {4{32'hdeadbeef}};
    repeat (3) tick();
    req_valid_i = 1'b0;
    check("full_hold_count", q_count_o, 3'd4);
    wait_done(6, 3000);
    check("full_peak", q_peak, 4);
    check("full_left", exp_q.size(), 0);
    check("full_err",  err_cnt, 0);

    // Timeout: memory never accepts the first entry; the next still writes.
    m_busy  = 3;
    m_stuck = 1;
    push_entry(32'h00003000, 16'd1, {4{32'h11111111}}, 0);
    push_entry(32'h00003000, 16'd2, {32'h22220000, 32'h22220001, 32'h22220002, 32'h22220003}, 4);
    wait_err(1, 600);
    m_stuck = 0;
    check("to_code", last_err, 2'd1);
    check("to_ce_cycles", err_run, 255);
    check("to_ce_dropped", mem_ce_o, 1'b0);
    wait_done(7, 300);
    check("to_left", exp_q.size(), 0);
    check("to_err_once", err_cnt, 1);

    // Reset during ACK of word 2: ce/we fall without a clock edge.
    m_busy = 10;
    w0 = wr_cnt;
    d0 = done_cnt;
    push_entry(32'h00004000, 16'd3, {32'h44440000, 32'h44440001, 32'h44440002, 32'h44440003}, 3);
    push_entry(32'h00004000, 16'd4, {4{32'h55555555}}, 0);
    wait_wr(w0 + 3, 300);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ce",     mem_ce_o,    1'b0);
    check("arst_we",     mem_we_o,    1'b0);
    check("arst_qcount", q_count_o,   3'd0);
    check("arst_busy",   busy_o,      1'b0);
    check("arst_ready",  req_ready_o, 1'b1);
    repeat (2) tick();
    rst_n = 1'b1;
    c0 = ce_total;
    repeat (40) tick();
    check("arst_no_done", done_cnt, d0);
    check("arst_no_ce",   ce_total, c0);
    check("arst_left",    exp_q.size(), 0);

    // Address wrap-around
    m_busy = 1;
    exp_q.push_back({32'hfffffff8, 32'h66660000});
    exp_q.push_back({32'hfffffffc, 32'h66660001});
    exp_q.push_back({32'h00000000, 32'h66660002});
    exp_q.push_back({32'h00000004, 32'h66660003});
    push_entry(32'hfffffff8, 16'd0, {32'h66660000, 32'h66660001, 32'h66660002, 32'h66660003}, 0);
    wait_done(d0 + 1, 300);
    check("wrap_left", exp_q.size(), 0);

`ifdef FLOW_WR_VERIFY_EN
    // Read-back of word 1 is corrupted: words 2-3 must never be written.
    e0 = err_cnt;
    d0 = done_cnt;
    m_corrupt      = 1;
    m_corrupt_addr = 32'h00005054;
    push_entry(32'h00005000, 16'd5, {32'h77770000, 32'h77770001, 32'h77770002, 32'h77770003}, 2);
    wait_err(e0 + 1, 300);
    m_corrupt = 0;
    check("vfy_code", last_err, 2'd2);
    repeat (20) tick();
    check("vfy_left",    exp_q.size(), 0);
    check("vfy_no_done", done_cnt, d0);
    check("vfy_reads",   rd_cnt > 0, 1'b1);
`else
    e0 = err_cnt;
    check("no_reads", rd_cnt, 0);
    check("no_new_err", err_cnt, e0);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
